bk_sector_ctrl: RTL and testbench

- Multi-slot backup-RAM sector streamer; successor to the single-slot cartridge save/load sequencer in the top level.
- Drives the hps_io SD sector handshake (sd_lba/sd_rd/sd_wr/sd_ack) to load or save N 512-byte sectors into one of 2^SLOT_BITS save slots in the mounted image.
- Adds over the previous generation: slot select, dirty tracking, done pulse, ack timeout with sticky error.
- Data itself flows through the existing BSRAM dual-port RAM; this block only sequences LBAs and handshakes.

---
 rtl/bk_sector_ctrl_if.sv | 22 ++
 rtl/bk_sector_ctrl.sv | 174 +++++++++++++++++
 tb/tb_bk_sector_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bk_sector_ctrl_if.sv
// SD sector handshake between the backup streamer and hps_io.
// The streamer drives LBA and read/write requests; hps_io returns ack.
interface bk_sector_ctrl_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        output sd_ack
    );
endinterface

// File: rtl/bk_sector_ctrl.sv
// Multi-slot backup-RAM sector streamer: sequences LBAs and the SD
// handshake for load/save of a save slot, tracks dirty state and timeouts.
module bk_sector_ctrl #(
    parameter int          SLOT_BITS   = 2,
    parameter int          SECT_BITS   = 6,
    parameter logic [23:0] ACK_TIMEOUT = 24'd10000000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ena,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic                 autoload,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic [SECT_BITS-1:0] last_sector,
    input  logic                 ram_wr,
    bk_sector_ctrl_if.master     sd,
    output logic                 busy,
    output logic                 loading,
    output logic                 dirty,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_FIN
    } state_e;

    localparam int          PAD     = 32 - SLOT_BITS - SECT_BITS;
    localparam logic [23:0] TO_LAST = ACK_TIMEOUT - 24'd1;
    localparam logic [SECT_BITS-1:0] SECT_ONE =
        {{(SECT_BITS-1){1'b0}}, 1'b1};

    state_e               state_q;
    logic                 ldreq_q;
    logic                 svreq_q;
    logic                 ack_q;
    logic [SLOT_BITS-1:0] slot_q;
    logic [SECT_BITS-1:0] sect_q;
    logic [SECT_BITS-1:0] last_q;
    logic [23:0]          cnt_q;
    logic                 is_load_q;
    logic                 wr_seen_q;
    logic                 rd_q;
    logic                 wr_q;
    logic                 busy_q;
    logic                 loading_q;
    logic                 dirty_q;
    logic                 done_q;
    logic                 err_q;

    logic ld_go;
    logic sv_go;
    logic ack_rise;
    logic ack_fall;
    logic to_hit;

    assign ld_go    = (load_req & ~ldreq_q) | autoload;
    assign sv_go    = save_req & ~svreq_q;
    assign ack_rise = sd.sd_ack & ~ack_q;
    assign ack_fall = ~sd.sd_ack & ack_q;
    assign to_hit   = (ACK_TIMEOUT != 24'd0) && (cnt_q == TO_LAST);

    // Edge registers reset high so a request held through reset is not an edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ldreq_q   <= 1'b1;
            svreq_q   <= 1'b1;
            ack_q     <= 1'b0;
            slot_q    <= '0;
            sect_q    <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
            wr_seen_q <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            loading_q <= 1'b0;
            dirty_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ldreq_q <= load_req;
            svreq_q <= save_req;
            ack_q   <= sd.sd_ack;
            done_q  <= 1'b0;

            if (ram_wr && !loading_q) begin
                dirty_q   <= 1'b1;
                wr_seen_q <= 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (ena && (ld_go || sv_go)) begin
                        state_q   <= S_REQ;
                        slot_q    <= slot;
                        sect_q    <= '0;
                        last_q    <= last_sector;
                        cnt_q     <= '0;
                        is_load_q <= ld_go;
                        wr_seen_q <= 1'b0;
                        rd_q      <= ld_go;
                        wr_q      <= ~ld_go;
                        busy_q    <= 1'b1;
                        loading_q <= ld_go;
                        err_q     <= 1'b0;
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 24'd1;
                    if (ack_rise) begin
                        state_q <= S_XFER;
                        cnt_q   <= '0;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end else if (to_hit) begin
                        state_q   <= S_IDLE;
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        loading_q <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                S_XFER: begin
                    cnt_q <= cnt_q + 24'd1;
                    if (ack_fall) begin
                        cnt_q <= '0;
                        if (sect_q == last_q) begin
                            state_q   <= S_FIN;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            loading_q <= 1'b0;
                        end else begin
                            state_q <= S_REQ;
                            sect_q  <= sect_q + SECT_ONE;
                            rd_q    <= is_load_q;
                            wr_q    <= ~is_load_q;
                        end
                    end else if (to_hit) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        loading_q <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    // A save only cleans the RAM if nothing wrote it meanwhile.
                    if (!ram_wr && (is_load_q || !wr_seen_q)) begin
                        dirty_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sd.sd_lba = {{PAD{1'b0}}, slot_q, sect_q};
    assign sd.sd_rd  = rd_q;
    assign sd.sd_wr  = wr_q;
    assign busy      = busy_q;
    assign loading   = loading_q;
    assign dirty     = dirty_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bk_sector_ctrl.sv
// Randomized self-checking bench for bk_sector_ctrl against a
// sector-list / dirty-flag reference model.
module tb_bk_sector_ctrl;
    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic       load_req = 1'b0;
    logic       save_req = 1'b0;
    logic       autoload = 1'b0;
    logic [1:0] slot = '0;
    logic [5:0] last_sector = '0;
    logic       ram_wr = 1'b0;
    logic       busy, loading, dirty, done, err;

    int checks = 0;
    int errors = 0;
    bit model_dirty = 1'b0;

    bk_sector_ctrl_if sd();

    bk_sector_ctrl #(
        .SLOT_BITS(2),
        .SECT_BITS(6),
        .ACK_TIMEOUT(24'd100)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ena(ena),
        .load_req(load_req),
        .save_req(save_req),
        .autoload(autoload),
        .slot(slot),
        .last_sector(last_sector),
        .ram_wr(ram_wr),
        .sd(sd.master),
        .busy(busy),
        .loading(loading),
        .dirty(dirty),
        .done(done),
        .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start(input bit is_load, input bit use_auto,
                         input logic [1:0] s, input logic [5:0] l);
        slot = s;
        last_sector = l;
        if (use_auto) autoload = 1'b1;
        else if (is_load) load_req = 1'b1;
        else save_req = 1'b1;
        step();
        autoload = 1'b0;
        load_req = 1'b0;
        save_req = 1'b0;
        checks++;
        if ({busy, loading, err} !== {1'b1, is_load, 1'b0}) begin
            errors++;
            $display("FAIL accept_status got busy/loading/err %b%b%b want 1%b0",
                     busy, loading, err, is_load);
        end
        checks++;
        if ({sd.sd_rd, sd.sd_wr} !== {is_load, ~is_load}) begin
            errors++;
            $display("FAIL accept_rdwr got %b%b want %b%b",
                     sd.sd_rd, sd.sd_wr, is_load, ~is_load);
        end
        checks++;
        if (sd.sd_lba !== 32'(int'(s) * 64)) begin
            errors++;
            $display("FAIL accept_lba got %h want %h",
                     sd.sd_lba, 32'(int'(s) * 64));
        end
    endtask

    // Acts as hps_io for every sector; wr_at picks a sector (or last+1
    // for the FIN cycle) where the CPU writes the RAM.
    task automatic serve(input bit is_load, input logic [1:0] s,
                         input logic [5:0] l, input int wr_at);
        bit wseen;
        wseen = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            int w;
            w = 0;
            while (!(sd.sd_rd | sd.sd_wr) && w < 20) begin
                step();
                w++;
            end
            checks++;
            if (!(sd.sd_rd | sd.sd_wr)) begin
                errors++;
                $display("FAIL req_wait sector %0d got none want request", i);
                return;
            end
            checks++;
            if (sd.sd_lba !== 32'(int'(s) * 64 + i)) begin
                errors++;
                $display("FAIL sector_lba got %h want %h",
                         sd.sd_lba, 32'(int'(s) * 64 + i));
            end
            checks++;
            if ({sd.sd_rd, sd.sd_wr} !== {is_load, ~is_load}) begin
                errors++;
                $display("FAIL sector_rdwr got %b%b want %b%b",
                         sd.sd_rd, sd.sd_wr, is_load, ~is_load);
            end
            if (i == wr_at) begin
                ram_wr = 1'b1;
                step();
                ram_wr = 1'b0;
                if (!is_load) begin
                    model_dirty = 1'b1;
                    wseen = 1'b1;
                end
            end
            repeat ($urandom_range(0, 3)) step();
            sd.sd_ack = 1'b1;
            step();
            checks++;
            if ({sd.sd_rd, sd.sd_wr} !== 2'b00) begin
                errors++;
                $display("FAIL ack_clear got %b%b want 00", sd.sd_rd, sd.sd_wr);
            end
            repeat ($urandom_range(0, 4)) step();
            sd.sd_ack = 1'b0;
            step();
            if (i == int'(l)) begin
                checks++;
                if ({done, busy, loading} !== 3'b100) begin
                    errors++;
                    $display("FAIL fin_pulse got done/busy/loading %b%b%b want 100",
                             done, busy, loading);
                end
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL early_done got %b want 0", done);
                end
            end
        end
        if (wr_at == int'(l) + 1) ram_wr = 1'b1;
        step();
        ram_wr = 1'b0;
        if (wr_at == int'(l) + 1) model_dirty = 1'b1;
        else if (is_load || !wseen) model_dirty = 1'b0;
        checks++;
        if ({done, busy, err} !== 3'b000) begin
            errors++;
            $display("FAIL after_fin got done/busy/err %b%b%b want 000",
                     done, busy, err);
        end
        checks++;
        if (dirty !== model_dirty) begin
            errors++;
            $display("FAIL dirty_after got %b want %b", dirty, model_dirty);
        end
    endtask

    task automatic make_dirty();
        ram_wr = 1'b1;
        step();
        ram_wr = 1'b0;
        model_dirty = 1'b1;
        checks++;
        if (dirty !== 1'b1) begin
            errors++;
            $display("FAIL idle_wr_dirty got %b want 1", dirty);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, loading, dirty, done, err, sd.sd_rd, sd.sd_wr} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000000",
                     {busy, loading, dirty, done, err, sd.sd_rd, sd.sd_wr});
        end
        checks++;
        if (sd.sd_lba !== 32'd0) begin
            errors++;
            $display("FAIL reset_lba got %h want 0", sd.sd_lba);
        end
        ena = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        checks++;
        if ({busy, sd.sd_rd, sd.sd_wr} !== 3'b000) begin
            errors++;
            $display("FAIL held_req_after_reset got %b want 000",
                     {busy, sd.sd_rd, sd.sd_wr});
        end
        load_req = 1'b0;
        save_req = 1'b0;
        step();
    endtask

    task automatic test_save_seq();
        make_dirty();
        start(1'b0, 1'b0, 2'd2, 6'd3);
        serve(1'b0, 2'd2, 6'd3, -1);
    endtask

    task automatic test_autoload();
        start(1'b1, 1'b1, 2'd0, 6'd0);
        serve(1'b1, 2'd0, 6'd0, -1);
    endtask

    task automatic test_priority();
        bit any;
        slot = 2'd1;
        last_sector = 6'd1;
        load_req = 1'b1;
        save_req = 1'b1;
        step();
        load_req = 1'b0;
        save_req = 1'b0;
        checks++;
        if ({sd.sd_rd, sd.sd_wr} !== 2'b10) begin
            errors++;
            $display("FAIL priority_rdwr got %b%b want 10", sd.sd_rd, sd.sd_wr);
        end
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        serve(1'b1, 2'd1, 6'd1, -1);
        any = 1'b0;
        repeat (6) begin
            step();
            any |= busy | sd.sd_rd | sd.sd_wr;
        end
        checks++;
        if (any !== 1'b0) begin
            errors++;
            $display("FAIL busy_req_queued got %b want 0", any);
        end
        ena = 1'b0;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ena_low_accept got %b want 0", busy);
        end
        ena = 1'b1;
        step();
    endtask

    task automatic test_dirty();
        make_dirty();
        start(1'b0, 1'b0, 2'd0, 6'd2);
        serve(1'b0, 2'd0, 6'd2, 1);
        start(1'b1, 1'b0, 2'd3, 6'd1);
        serve(1'b1, 2'd3, 6'd1, 0);
        start(1'b0, 1'b0, 2'd1, 6'd0);
        serve(1'b0, 2'd1, 6'd0, 1);
        start(1'b0, 1'b0, 2'd1, 6'd1);
        serve(1'b0, 2'd1, 6'd1, -1);
    endtask

    task automatic test_timeout();
        int k;
        make_dirty();
        start(1'b1, 1'b0, 2'd3, 6'd0);
        k = 0;
        for (int j = 1; j <= 150; j++) begin
            step();
            if (busy === 1'b0) begin
                k = j;
                break;
            end
        end
        checks++;
        if (k != 100) begin
            errors++;
            $display("FAIL timeout_cycle got %0d want 100", k);
        end
        checks++;
        if ({err, sd.sd_rd, loading, done} !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_state got err/rd/loading/done %b want 1000",
                     {err, sd.sd_rd, loading, done});
        end
        checks++;
        if (dirty !== model_dirty) begin
            errors++;
            $display("FAIL timeout_dirty got %b want %b", dirty, model_dirty);
        end
        repeat (3) step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", err);
        end
        start(1'b0, 1'b0, 2'd1, 6'd0);
        serve(1'b0, 2'd1, 6'd0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            bit         ld;
            logic [1:0] s;
            logic [5:0] l;
            int         wa;
            ld = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            l = 6'($urandom_range(0, 5));
            wa = int'($urandom_range(0, int'(l) + 2)) - 1;
            if ($urandom_range(0, 1) == 1) make_dirty();
            start(ld, 1'b0, s, l);
            serve(ld, s, l, wa);
            repeat ($urandom_range(1, 3)) step();
        end
        start(1'b1, 1'b0, 2'd3, 6'd63);
        serve(1'b1, 2'd3, 6'd63, -1);
    endtask

    task automatic test_reset_mid();
        bit any;
        start(1'b1, 1'b0, 2'd1, 6'd3);
        for (int i = 0; i < 2; i++) begin
            sd.sd_ack = 1'b1;
            step();
            step();
            sd.sd_ack = 1'b0;
            step();
        end
        sd.sd_ack = 1'b1;
        step();
        step();
        load_req = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, loading, dirty, done, err, sd.sd_rd, sd.sd_wr} !== 7'd0) begin
            errors++;
            $display("FAIL async_reset got %b want 0000000",
                     {busy, loading, dirty, done, err, sd.sd_rd, sd.sd_wr});
        end
        checks++;
        if (sd.sd_lba !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_lba got %h want 0", sd.sd_lba);
        end
        model_dirty = 1'b0;
        sd.sd_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        any = 1'b0;
        repeat (8) begin
            step();
            any |= busy | sd.sd_rd | sd.sd_wr | done;
        end
        checks++;
        if (any !== 1'b0) begin
            errors++;
            $display("FAIL held_load_after_reset got %b want 0", any);
        end
        load_req = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        load_req = 1'b1;
        save_req = 1'b1;
        sd.sd_ack = 1'b0;
        test_reset();
        test_save_seq();
        test_autoload();
        test_priority();
        test_dirty();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
